// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding and default sizes for the DDS request master.
package dds_pkg;
   localparam int ADDR_W_DEF  = 10;
   localparam int DATA_W_DEF  = 14;
   localparam int TIMEOUT_DEF = 64;
   localparam int DIV_W       = 16;
   typedef enum logic [1:0] {IDLE, WAIT_TICK, REQ, WAIT_ACK} state_t;
endpackage

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: phase register with load/advance controls.
// DDS_SWEEP_EN adds a saturating linear increment sweep (chirp).
module dds_phase_acc
   import dds_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              adv,
   input  logic [ADDR_W-1:0] phase0,
   input  logic [ADDR_W-1:0] inc,
`ifdef DDS_SWEEP_EN
   input  logic [ADDR_W-1:0] sweep_step,
   input  logic [ADDR_W-1:0] sweep_max,
`endif
   output logic [ADDR_W-1:0] phase
);
   logic [ADDR_W-1:0] phase_q, phase_d;
`ifdef DDS_SWEEP_EN
   logic [ADDR_W-1:0] inc_q, inc_d;
   logic [ADDR_W:0]   inc_sum;
   always_comb begin
      inc_sum = {1'b0, inc_q} + {1'b0, sweep_step};
      phase_d = load ? phase0 : adv ? phase_q + inc_q : phase_q;
      inc_d   = load ? inc :
                adv  ? (inc_sum > {1'b0, sweep_max} ? sweep_max : inc_sum[ADDR_W-1:0]) : inc_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) inc_q <= '0;
      else     inc_q <= inc_d;
`else
   always_comb phase_d = load ? phase0 : adv ? phase_q + inc : phase_q;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
   assign phase = phase_q;
endmodule

// File: rtl/dds_req_master.sv
// dds_req_master: paced DDS lookup initiator with ack timeout and registered DAC output.
// Define DDS_SWEEP_EN to add reg_sweep_step/reg_sweep_max and a chirped phase increment.
module dds_req_master
   import dds_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [ADDR_W-1:0] reg_dds_inc,
   input  logic [ADDR_W-1:0] reg_dds_phase0,
   input  logic [DIV_W-1:0]  reg_sample_div,
`ifdef DDS_SWEEP_EN
   input  logic [ADDR_W-1:0] reg_sweep_step,
   input  logic [ADDR_W-1:0] reg_sweep_max,
`endif
   input  logic              sel_backward,
   input  logic              err_clr,
   output logic              dds_req,
   output logic [ADDR_W-1:0] dds_addr,
   input  logic              dds_ack,
   input  logic [DATA_W-1:0] dds_data_forward,
   input  logic [DATA_W-1:0] dds_data_backward,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_valid,
   output logic              busy,
   output logic              timeout_err
);
   localparam int TO_W = $clog2(TIMEOUT);
   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d, div_eff;
   logic [DIV_W:0]    div_nxt;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [DATA_W-1:0] dac_data_q, dac_data_d;
   logic              dac_valid_q, dac_valid_d, err_q, err_d;
   logic              load, adv, to_hit;
   dds_phase_acc #(.ADDR_W(ADDR_W)) u_acc (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .adv        (adv),
      .phase0     (reg_dds_phase0),
      .inc        (reg_dds_inc),
`ifdef DDS_SWEEP_EN
      .sweep_step (reg_sweep_step),
      .sweep_max  (reg_sweep_max),
`endif
      .phase      (dds_addr)
   );
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      to_cnt_d  = to_cnt_q;
      load      = 1'b0;
      adv       = 1'b0;
      to_hit    = 1'b0;
      div_eff   = reg_sample_div == '0 ? DIV_W'(1) : reg_sample_div;
      div_nxt   = {1'b0, div_cnt_q} + (DIV_W+1)'(1);
      case (state_q)
         IDLE: if (en) begin
            load      = 1'b1;
            div_cnt_d = '0;
            state_d   = WAIT_TICK;
         end
         WAIT_TICK:
            if (!en) state_d = IDLE;
            else if (div_nxt >= {1'b0, div_eff}) begin
               div_cnt_d = '0;
               state_d   = REQ;
            end else div_cnt_d = div_nxt[DIV_W-1:0];
         REQ: begin
            to_cnt_d = '0;
            state_d  = WAIT_ACK;
         end
         WAIT_ACK:
            // an ack on the last timeout cycle still counts as a good transaction
            if (dds_ack) begin
               adv     = 1'b1;
               state_d = en ? WAIT_TICK : IDLE;
            end else if (to_cnt_q == TO_W'(TIMEOUT-1)) begin
               to_hit  = 1'b1;
               state_d = en ? WAIT_TICK : IDLE;
            end else to_cnt_d = to_cnt_q + TO_W'(1);
         default: state_d = IDLE;
      endcase
      dac_valid_d = adv;
      dac_data_d  = adv ? (sel_backward ? dds_data_backward : dds_data_forward) : dac_data_q;
      err_d       = to_hit | (err_q & ~err_clr);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         div_cnt_q   <= '0;
         to_cnt_q    <= '0;
         dac_data_q  <= '0;
         dac_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         to_cnt_q    <= to_cnt_d;
         dac_data_q  <= dac_data_d;
         dac_valid_q <= dac_valid_d;
         err_q       <= err_d;
      end
   assign dds_req     = state_q == REQ;
   assign busy        = state_q != IDLE;
   assign dac_data    = dac_data_q;
   assign dac_valid   = dac_valid_q;
   assign timeout_err = err_q;
endmodule
